// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - byte-stream to 32-bit instruction memory writer with core reset hold
//
// Purpose:
//   Packs an incoming byte stream into little-endian 32-bit words and writes them
//   to the instruction memory starting at BASE_ADDR. Keeps the CPU core in reset
//   until the complete program has been written.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   Start         in   load request pulse (sampled in IDLE and DONE only)
//   LoadLength    in   program length in bytes, latched with an accepted Start
//   ByteValid     in   ByteData is valid
//   ByteData      in   stream byte, first byte lands at the lowest address
//   ByteReady     out  byte accepted this cycle when ByteValid is also high
//   WriteEnable   out  one-cycle memory write strobe per word
//   WriteAddress  out  word-aligned byte address of the write
//   WriteData     out  little-endian write word
//   WriteStrobe   out  byte-lane enables for WriteData
//   Done          out  load complete
//   Error         out  sticky flag for a rejected Start
//   CpuResetHold  out  1 keeps the core in reset

module imem_program_loader #(
  parameter int MEM_SIZE   = 1024,
  parameter int ADDR_WIDTH = 32,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Start,
  input  logic [ADDR_WIDTH-1:0] LoadLength,
  input  logic                  ByteValid,
  input  logic [7:0]            ByteData,
  output logic                  ByteReady,
  output logic                  WriteEnable,
  output logic [ADDR_WIDTH-1:0] WriteAddress,
  output logic [31:0]           WriteData,
  output logic [3:0]            WriteStrobe,
  output logic                  Done,
  output logic                  Error,
  output logic                  CpuResetHold
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] MAX_LEN = ADDR_WIDTH'(MEM_SIZE - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE    = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] len;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_inc;
  logic [31:0]           word_buf;
  logic [31:0]           buf_merged;
  logic [3:0]            lane_mask;
  logic                  start_window;
  logic                  len_ok;
  logic                  start_acc;
  logic                  start_rej;
  logic                  xfer;
  logic                  word_end;

  // Start is only honoured while no load is in flight.
  assign start_window = (state == ST_IDLE) || (state == ST_DONE);
  assign len_ok       = (LoadLength != '0) && (LoadLength <= MAX_LEN);
  assign start_acc    = start_window && Start && len_ok;
  assign start_rej    = start_window && Start && !len_ok;

  assign xfer     = (state == ST_LOAD) && ByteValid;
  assign cnt_inc  = cnt + ONE;
  // A word is complete when lane 3 is filled or the final program byte arrives.
  assign word_end = (cnt[1:0] == 2'd3) || (cnt_inc == len);

  // Buffer contents including the byte being transferred, and the lanes that
  // hold real data once this byte is in (lanes above it stay zero).
  always_comb begin
    buf_merged = word_buf;
    lane_mask  = 4'b0001;
    case (cnt[1:0])
      2'd0: begin
        buf_merged[7:0] = ByteData;
        lane_mask       = 4'b0001;
      end
      2'd1: begin
        buf_merged[15:8] = ByteData;
        lane_mask        = 4'b0011;
      end
      2'd2: begin
        buf_merged[23:16] = ByteData;
        lane_mask         = 4'b0111;
      end
      default: begin
        buf_merged[31:24] = ByteData;
        lane_mask         = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ByteReady    = 1'b0;
    WriteEnable  = 1'b0;
    Done         = 1'b0;
    CpuResetHold = 1'b1;
    case (state)
      ST_IDLE: begin
        if (start_acc) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ByteReady = 1'b1;
        if (xfer && word_end) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        WriteEnable = 1'b1;
        // cnt has already advanced past the word just written.
        state_nxt   = (cnt == len) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        Done         = 1'b1;
        CpuResetHold = 1'b0;
        if (start_acc) begin
          state_nxt = ST_LOAD;
        end else if (start_rej) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Write port registers are loaded on the transfer that completes a word so
  // they are valid during WRITE and hold their values afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len          <= '0;
      cnt          <= '0;
      word_buf     <= '0;
      Error        <= 1'b0;
      WriteAddress <= '0;
      WriteData    <= '0;
      WriteStrobe  <= '0;
    end else begin
      if (start_acc) begin
        len      <= LoadLength;
        cnt      <= '0;
        word_buf <= '0;
        Error    <= 1'b0;
      end else if (start_rej) begin
        Error <= 1'b1;
      end

      if (xfer) begin
        word_buf <= buf_merged;
        cnt      <= cnt_inc;
        if (word_end) begin
          WriteAddress <= BASE + {cnt[ADDR_WIDTH-1:2], 2'b00};
          WriteData    <= buf_merged;
          WriteStrobe  <= lane_mask;
        end
      end

      if (state == ST_WRITE) begin
        word_buf <= '0;
      end
    end
  end

endmodule
